// File: rtl/qsys_led_pio_blink.sv
// Avalon-MM LED output port: WIDTH channels, each static or blinking from a
// shared programmable-rate phase generator, with an optional self-stopping burst.
module qsys_led_pio_blink #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 26,
  parameter int PERIOD_RST = 25000000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  output logic [WIDTH-1:0]   out_port
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_BLINK  = 3'd1;
  localparam logic [2:0] ADDR_SET    = 3'd2;
  localparam logic [2:0] ADDR_CLEAR  = 3'd3;
  localparam logic [2:0] ADDR_PERIOD = 3'd4;
  localparam logic [2:0] ADDR_BURST  = 3'd5;
  localparam logic [2:0] ADDR_STATUS = 3'd6;

  localparam logic [PRESCALE_W-1:0] PERIOD_INIT = PRESCALE_W'(PERIOD_RST);
  localparam logic [PRESCALE_W-1:0] CNT_ONE     = PRESCALE_W'(1);

  logic [WIDTH-1:0]      r_data;
  logic [WIDTH-1:0]      r_blink_en;
  logic [PRESCALE_W-1:0] r_period;
  logic [PRESCALE_W-1:0] r_cnt;
  logic [7:0]            r_burst;
  logic                  r_phase;

  logic                  w_wr;
  logic                  w_wr_data;
  logic                  w_wr_blink;
  logic                  w_wr_set;
  logic                  w_wr_clr;
  logic                  w_wr_period;
  logic                  w_wr_burst;
  logic                  w_restart;
  logic                  w_tick;
  logic                  w_fall;
  logic                  w_burst_dec;
  logic                  w_burst_end;
  logic [WIDTH-1:0]      w_wdata;
  logic [31:0]           w_rdata;
  logic                  w_unused;

  assign w_wr        = chipselect & ~write_n;
  assign w_wr_data   = w_wr & (address == ADDR_DATA);
  assign w_wr_blink  = w_wr & (address == ADDR_BLINK);
  assign w_wr_set    = w_wr & (address == ADDR_SET);
  assign w_wr_clr    = w_wr & (address == ADDR_CLEAR);
  assign w_wr_period = w_wr & (address == ADDR_PERIOD);
  assign w_wr_burst  = w_wr & (address == ADDR_BURST);
  assign w_wdata     = writedata[WIDTH-1:0];
  assign w_unused    = ^writedata;

  // A BLINK_EN/PERIOD write restarts the phase in its visible half; that beats a
  // tick on the same edge, so such an edge is never a 1->0 phase transition.
  assign w_restart   = w_wr_blink | w_wr_period;
  assign w_tick      = (r_cnt == r_period);
  assign w_fall      = w_tick & r_phase & ~w_restart;
  assign w_burst_dec = w_fall & (r_burst != 8'd0);
  assign w_burst_end = w_burst_dec & (r_burst == 8'd1) & ~w_wr_burst;

  // Static LED value with write-1-set / write-1-clear aliases.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= '0;
    end else if (w_wr_data) begin
      r_data <= w_wdata;
    end else if (w_wr_set) begin
      r_data <= r_data | w_wdata;
    end else if (w_wr_clr) begin
      r_data <= r_data & ~w_wdata;
    end else begin
      r_data <= r_data;
    end
  end

  // Blink enables; a completed burst drops them unless software writes them now.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_en <= '0;
    end else if (w_wr_blink) begin
      r_blink_en <= w_wdata;
    end else if (w_burst_end) begin
      r_blink_en <= '0;
    end else begin
      r_blink_en <= r_blink_en;
    end
  end

  // Half-period register and remaining-burst counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_period <= PERIOD_INIT;
      r_burst  <= 8'd0;
    end else begin
      if (w_wr_period) begin
        r_period <= writedata[PRESCALE_W-1:0];
      end else begin
        r_period <= r_period;
      end
      if (w_wr_burst) begin
        r_burst <= writedata[7:0];
      end else if (w_burst_dec) begin
        r_burst <= r_burst - 8'd1;
      end else begin
        r_burst <= r_burst;
      end
    end
  end

  // Prescaler; restarting from 0 means a shrunken PERIOD can never strand cnt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (w_restart) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (w_tick) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + CNT_ONE;
      r_phase <= r_phase;
    end
  end

  // Zero-latency read mux; unimplemented bits read as zero.
  always_comb begin
    w_rdata = 32'd0;
    case (address)
      ADDR_DATA:   w_rdata[WIDTH-1:0]      = r_data;
      ADDR_BLINK:  w_rdata[WIDTH-1:0]      = r_blink_en;
      ADDR_PERIOD: w_rdata[PRESCALE_W-1:0] = r_period;
      ADDR_BURST:  w_rdata[7:0]            = r_burst;
      ADDR_STATUS: w_rdata[1:0]            = {(r_blink_en != '0), r_phase};
      default:     w_rdata                 = 32'd0;
    endcase
  end

  assign readdata = w_rdata;
  assign out_port = r_data & (~r_blink_en | {WIDTH{r_phase}});

endmodule

// File: tb/tb_qsys_led_pio_blink.sv
// Self-checking bench for qsys_led_pio_blink: register vector table plus
// hand-written blink, burst, restart and asynchronous-reset sequences.
module tb_qsys_led_pio_blink;

  localparam int WIDTH      = 8;
  localparam int PRESCALE_W = 26;
  localparam int PERIOD_RST = 25000000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  qsys_led_pio_blink #(
    .WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W), .PERIOD_RST(PERIOD_RST)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [7:0]  exp_out;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] q_out[$];
  logic [31:0] q_rd[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input bit wr, input logic [2:0] a, input logic [31:0] d,
                     input logic [7:0] eo, input logic [31:0] er);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.exp_out = eo; v.exp_rd = er;
    vecs.push_back(v);
  endtask

  task automatic run_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      chipselect = 1'b1;
      write_n    = ~vecs[i].wr;
      address    = vecs[i].addr;
      writedata  = vecs[i].data;
      q_out.push_back({24'd0, vecs[i].exp_out});
      if (!vecs[i].wr) begin
        #1;
        check($sformatf("%s%0d_rd", tag, i), readdata, vecs[i].exp_rd);
      end
      @(posedge clk); #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
      check($sformatf("%s%0d_out", tag, i), {24'd0, out_port}, q_out.pop_front());
    end
    vecs.delete();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic setrd(input logic [2:0] a);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    #1;
  endtask

  task automatic add_reset_reads();
    for (int a = 0; a < 8; a++)
      add(1'b0, 3'(a), 32'd0, 8'h00, (a == 4) ? 32'(PERIOD_RST) : 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_on4[10];
    logic [7:0] exp_b4[10];
    logic       exp_ph5[7];

    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 32'd0;
    #2;
    check("reset_out", {24'd0, out_port}, 32'd0);
    #10 reset_n = 1'b1;
    @(posedge clk); #1;

    // Reset read-back, then static DATA / SET / CLEAR and truncation.
    add_reset_reads();
    add(1'b1, 3'd0, 32'hFFFF_FFA5, 8'hA5, 32'd0);
    add(1'b1, 3'd2, 32'h0000_000A, 8'hAF, 32'd0);
    add(1'b1, 3'd3, 32'h0000_0081, 8'h2E, 32'd0);
    add(1'b0, 3'd0, 32'd0,         8'h2E, 32'h0000_002E);
    add(1'b0, 3'd2, 32'd0,         8'h2E, 32'd0);
    add(1'b0, 3'd3, 32'd0,         8'h2E, 32'd0);
    add(1'b1, 3'd7, 32'h0000_00FF, 8'h2E, 32'd0);
    add(1'b0, 3'd7, 32'd0,         8'h2E, 32'd0);
    add(1'b0, 3'd1, 32'd0,         8'h2E, 32'd0);
    add(1'b1, 3'd4, 32'hFFFF_FFFF, 8'h2E, 32'd0);
    add(1'b0, 3'd4, 32'd0,         8'h2E, 32'h03FF_FFFF);
    add(1'b0, 3'd6, 32'd0,         8'h2E, 32'h0000_0001);
    run_vecs("vec");

    // Continuous blink, PERIOD = 3: four cycles on, four cycles off.
    wr(3'd4, 32'd3);
    wr(3'd0, 32'hFF);
    wr(3'd1, 32'h0F);
    for (int k = 0; k < 16; k++) begin
      q_out.push_back(((k / 4) % 2 == 0) ? 32'hFF : 32'hF0);
      q_rd.push_back({30'd0, 1'b1, ((k / 4) % 2 == 0)});
    end
    setrd(3'd6);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("blink_out%0d", k), {24'd0, out_port}, q_out.pop_front());
      check($sformatf("blink_status%0d", k), readdata, q_rd.pop_front());
      @(posedge clk); #1;
    end

    // Burst of 2 periods at PERIOD = 1, then automatic stop on a steady LED.
    wr(3'd1, 32'd0);
    wr(3'd4, 32'd1);
    wr(3'd0, 32'h01);
    wr(3'd1, 32'h01);
    wr(3'd5, 32'd2);
    exp_on4 = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    exp_b4  = '{8'd2, 8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    setrd(3'd5);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("burst_out%0d", k), {24'd0, out_port}, {24'd0, exp_on4[k]});
      check($sformatf("burst_cnt%0d", k), readdata, {24'd0, exp_b4[k]});
      @(posedge clk); #1;
    end
    setrd(3'd1);
    check("burst_blink_cleared", readdata, 32'd0);

    // Shrinking PERIOD from 7 to 2 while cnt = 5 restarts the phase at once.
    wr(3'd4, 32'd7);
    wr(3'd1, 32'h01);
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("period7_still_on", {24'd0, out_port}, 32'h01);
    wr(3'd4, 32'd2);
    exp_ph5 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    setrd(3'd6);
    for (int k = 0; k < 7; k++) begin
      check($sformatf("shrink_status%0d", k), readdata, {30'd0, 1'b1, exp_ph5[k]});
      check($sformatf("shrink_out%0d", k), {24'd0, out_port}, {31'd0, exp_ph5[k]});
      @(posedge clk); #1;
    end

    // BLINK_EN write on the edge where the burst would have expired.
    wr(3'd1, 32'h01);
    wr(3'd5, 32'd1);
    @(posedge clk); #1;
    wr(3'd1, 32'h03);
    setrd(3'd1);
    check("expire_write_wins", readdata, 32'h03);
    check("expire_out", {24'd0, out_port}, 32'h01);
    repeat (3) @(posedge clk);
    #1;
    check("expire_later", readdata, 32'd0);

    // Asynchronous reset mid-burst, not aligned to clk.
    wr(3'd0, 32'hFF);
    wr(3'd5, 32'd5);
    wr(3'd1, 32'hFF);
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("preburst_out", {24'd0, out_port}, 32'hFF);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_out", {24'd0, out_port}, 32'd0);
    #7 reset_n = 1'b1;
    @(posedge clk); #1;
    add_reset_reads();
    run_vecs("rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
